// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL lock detector.
// Contents: FSM state encoding, datapath widths, default thresholds and a
// small helper that measures the distance between two DLF codes.
package adpll_pkg;

    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned FBCNT_W  = 4;

    localparam int unsigned LOCK_CNT_DEF   = 8;
    localparam int unsigned UNLOCK_CNT_DEF = 2;
    localparam int unsigned CODE_TOL_DEF   = 1;
    localparam int unsigned FB_EXP_DEF     = 1;
    localparam int unsigned TIMEOUT_DEF    = 40000;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    // Absolute difference widened by one bit so the result never wraps
    // (0 against 15 yields 15).
    function automatic logic [CODE_W:0] code_dist(input logic [CODE_W-1:0] a,
                                                  input logic [CODE_W-1:0] b);
        logic [CODE_W:0] wa;
        logic [CODE_W:0] wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        return (wa >= wb) ? (wa - wb) : (wb - wa);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   din   - asynchronous input
//   pulse - one-cycle pulse, three clocks after a rising edge on din
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s2_d  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            s2_d  <= s2;
            pulse <= s2 & ~s2_d;
        end
    end

endmodule

// File: rtl/adpll_lock_detect.sv
// ADPLL lock detector. Every reference period is judged on the number of
// feedback edges it contained and on how far the DLF code moved since the
// previous period; a run of good periods declares lock and a run of bad
// periods while locked drops it. A missing reference forces the idle state.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   ref_in      - asynchronous reference clock
//   fb_in       - asynchronous divided feedback clock
//   code        - DLF control code, sampled on each internal reference edge
//   lock        - loop locked
//   lost_lock   - one-cycle pulse when the locked state is left
//   ref_lost    - no reference edge for TIMEOUT cycles
//   ref_period  - clk cycles in the last complete reference period
//   fb_edges    - feedback edges in the last period (saturating)
//   state       - 0 idle, 1 acquire, 2 locked
module adpll_lock_detect
    import adpll_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = LOCK_CNT_DEF,
    parameter int unsigned UNLOCK_CNT = UNLOCK_CNT_DEF,
    parameter int unsigned CODE_TOL   = CODE_TOL_DEF,
    parameter int unsigned FB_EXP     = FB_EXP_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ref_in,
    input  logic                fb_in,
    input  logic [CODE_W-1:0]   code,
    output logic                lock,
    output logic                lost_lock,
    output logic                ref_lost,
    output logic [PERIOD_W-1:0] ref_period,
    output logic [FBCNT_W-1:0]  fb_edges,
    output logic [1:0]          state
);

    localparam int unsigned RUN_W = 8;

    localparam logic [RUN_W-1:0]    LOCK_V    = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]    UNLOCK_V  = RUN_W'(UNLOCK_CNT);
    localparam logic [CODE_W:0]     TOL_V     = (CODE_W + 1)'(CODE_TOL);
    localparam logic [FBCNT_W-1:0]  FB_EXP_V  = FBCNT_W'(FB_EXP);
    localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);

    logic ref_edge;
    logic fb_edge;

    logic [PERIOD_W-1:0] period_cnt;
    logic [FBCNT_W-1:0]  fb_cnt;
    logic [FBCNT_W-1:0]  fb_total;
    logic [CODE_W-1:0]   prev_code;
    logic [RUN_W-1:0]    good_cnt;
    logic [RUN_W-1:0]    bad_cnt;
    logic                period_good;
    logic                timeout_hit;

    sync_edge u_ref_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ref_in),
        .pulse (ref_edge)
    );

    sync_edge u_fb_sync (
        .clk   (clk),
        .reset (reset),
        .din   (fb_in),
        .pulse (fb_edge)
    );

    // A feedback edge coinciding with the reference edge belongs to the
    // window that is closing, so it is folded in before evaluation.
    always_comb begin
        fb_total = fb_cnt;
        if (fb_edge && (fb_cnt != '1)) begin
            fb_total = fb_cnt + 1'b1;
        end
    end

    assign period_good = (fb_total == FB_EXP_V) && (code_dist(code, prev_code) <= TOL_V);
    assign timeout_hit = (period_cnt == TIMEOUT_V);
    assign lock        = (state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
            fb_cnt     <= '0;
            prev_code  <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            state      <= ST_IDLE;
            lost_lock  <= 1'b0;
            ref_lost   <= 1'b0;
            ref_period <= '0;
            fb_edges   <= '0;
        end else begin
            lost_lock <= 1'b0;

            if (ref_edge) begin
                period_cnt <= PERIOD_W'(1);
                fb_cnt     <= '0;
            end else begin
                if (period_cnt != '1) begin
                    period_cnt <= period_cnt + 1'b1;
                end
                fb_cnt <= fb_total;
            end

            // A reference edge takes priority over a simultaneous timeout.
            if (ref_edge) begin
                prev_code <= code;
                if (state != ST_IDLE) begin
                    ref_period <= period_cnt;
                    fb_edges   <= fb_total;
                end
                case (state)
                    ST_IDLE: begin
                        state    <= ST_ACQUIRE;
                        ref_lost <= 1'b0;
                        good_cnt <= '0;
                        bad_cnt  <= '0;
                    end
                    ST_ACQUIRE: begin
                        if (!period_good) begin
                            good_cnt <= '0;
                        end else if (good_cnt + 1'b1 == LOCK_V) begin
                            state    <= ST_LOCKED;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (period_good) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt + 1'b1 == UNLOCK_V) begin
                            state     <= ST_ACQUIRE;
                            good_cnt  <= '0;
                            bad_cnt   <= '0;
                            lost_lock <= 1'b1;
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (timeout_hit) begin
                lost_lock <= (state == ST_LOCKED);
                state     <= ST_IDLE;
                ref_lost  <= 1'b1;
                good_cnt  <= '0;
                bad_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adpll_lock_detect.sv
// Self-checking bench for adpll_lock_detect: directed scenarios plus a
// randomized run, checked every cycle against a timestamp-based model.
module tb_adpll_lock_detect;

    localparam int unsigned LOCK_N   = 8;
    localparam int unsigned UNLOCK_N = 2;
    localparam int unsigned TOL      = 1;
    localparam int unsigned FBX      = 1;
    localparam int unsigned T_OUT    = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        ref_in;
    logic        fb_in;
    logic [3:0]  code;
    logic        lock;
    logic        lost_lock;
    logic        ref_lost;
    logic [15:0] ref_period;
    logic [3:0]  fb_edges;
    logic [1:0]  state;

    adpll_lock_detect #(
        .LOCK_CNT   (LOCK_N),
        .UNLOCK_CNT (UNLOCK_N),
        .CODE_TOL   (TOL),
        .FB_EXP     (FBX),
        .TIMEOUT    (T_OUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ref_in     (ref_in),
        .fb_in      (fb_in),
        .code       (code),
        .lock       (lock),
        .lost_lock  (lost_lock),
        .ref_lost   (ref_lost),
        .ref_period (ref_period),
        .fb_edges   (fb_edges),
        .state      (state)
    );

    always #10 clk = ~clk;

    int n_checks    = 0;
    int n_errors    = 0;
    int lost_pulses = 0;
    bit model_valid = 1'b0;

    int e_state;
    int e_period;
    int e_fbe;
    int e_lock;
    int e_lost;
    int e_reflost;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins are edge-detected as sampled, delayed three
    // cycles, and each reference event closes a window whose length is the
    // time since the previous event.
    initial begin : model
        int since;
        int fbw;
        int fb_tot;
        int prev_code;
        int good;
        int bad;
        int d;
        bit rprev;
        bit fprev;
        bit [2:0] rdl;
        bit [2:0] fdl;
        bit ev_r;
        bit ev_f;
        forever begin
            @(posedge clk);
            if (reset) begin
                since = 0; fbw = 0; prev_code = 0; good = 0; bad = 0;
                rprev = 1'b0; fprev = 1'b0; rdl = '0; fdl = '0;
                e_state = 0; e_period = 0; e_fbe = 0;
                e_lock = 0; e_lost = 0; e_reflost = 0;
                model_valid = 1'b1;
            end else begin
                ev_r = rdl[2];
                ev_f = fdl[2];
                rdl = {rdl[1:0], ref_in & ~rprev};
                fdl = {fdl[1:0], fb_in & ~fprev};
                rprev = ref_in;
                fprev = fb_in;
                e_lost = 0;
                fb_tot = fbw + int'(ev_f);
                if (fb_tot > 15) fb_tot = 15;
                if (ev_r) begin
                    d = int'(code) - prev_code;
                    if (d < 0) d = -d;
                    if (e_state == 0) begin
                        e_state = 1; e_reflost = 0; good = 0; bad = 0;
                    end else begin
                        e_period = (since > 65535) ? 65535 : since;
                        e_fbe = fb_tot;
                        if (e_state == 1) begin
                            if (fb_tot == int'(FBX) && d <= int'(TOL)) good++;
                            else good = 0;
                            if (good == int'(LOCK_N)) begin
                                e_state = 2; good = 0; bad = 0;
                            end
                        end else begin
                            if (fb_tot == int'(FBX) && d <= int'(TOL)) bad = 0;
                            else bad++;
                            if (bad == int'(UNLOCK_N)) begin
                                e_state = 1; good = 0; bad = 0; e_lost = 1;
                            end
                        end
                    end
                    prev_code = int'(code);
                    since = 1;
                    fbw = 0;
                end else begin
                    if (since == int'(T_OUT)) begin
                        if (e_state == 2) e_lost = 1;
                        e_state = 0; e_reflost = 1; good = 0; bad = 0;
                    end
                    if (since < 65535) since++;
                    fbw = fb_tot;
                end
                e_lock = (e_state == 2) ? 1 : 0;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (lost_lock === 1'b1) lost_pulses++;
            if (model_valid) begin
                check("lock", int'(lock), e_lock);
                check("lost_lock", int'(lost_lock), e_lost);
                check("ref_lost", int'(ref_lost), e_reflost);
                check("ref_period", int'(ref_period), e_period);
                check("fb_edges", int'(fb_edges), e_fbe);
                check("state", int'(state), e_state);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_period(input int p, input int nfb, input int c, input bit aligned);
        for (int i = 0; i < p; i++) begin
            tick();
            if (i == 0) code = 4'(c);
            ref_in = (i < p / 2);
            fb_in = 1'b0;
            for (int k = 0; k < nfb; k++) begin
                int st;
                st = aligned ? (k * p / nfb) : ((k + 1) * p / (nfb + 1));
                if (i >= st && i < st + 4) fb_in = 1'b1;
            end
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            tick();
            ref_in = 1'b0;
            fb_in  = 1'b0;
        end
    endtask

    initial begin : stimulus
        int base;
        int c;
        int p;
        int nfb;
        bit al;
        reset = 1'b1; ref_in = 1'b0; fb_in = 1'b0; code = 4'd8;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_state", int'(state), 0);
        check("rst_lock", int'(lock), 0);
        check("rst_period", int'(ref_period), 0);
        gap(10);

        // Constant code, one feedback edge per period.
        repeat (8) run_period(200, 1, 8, 1'b0);
        check("acq_state", int'(state), 1);
        check("acq_lock", int'(lock), 0);
        run_period(200, 1, 8, 1'b0);
        check("lock_up", int'(lock), 1);
        check("lock_state", int'(state), 2);
        check("lock_period", int'(ref_period), 200);
        check("lock_fbe", int'(fb_edges), 1);

        // Code steps within and beyond tolerance.
        run_period(200, 1, 9, 1'b0);
        run_period(200, 1, 9, 1'b0);
        check("small_step_lock", int'(lock), 1);
        base = lost_pulses;
        run_period(200, 1, 11, 1'b0);
        check("one_bad_lock", int'(lock), 1);
        run_period(200, 1, 14, 1'b0);
        check("two_bad_lock", int'(lock), 0);
        check("two_bad_state", int'(state), 1);
        check("two_bad_pulses", lost_pulses - base, 1);

        // Extra feedback edges.
        repeat (8) run_period(200, 1, 14, 1'b0);
        check("relock", int'(lock), 1);
        run_period(200, 2, 14, 1'b0);
        run_period(200, 1, 14, 1'b0);
        check("dbl_fbe", int'(fb_edges), 2);
        check("dbl_lock", int'(lock), 1);
        run_period(200, 1, 14, 1'b0);
        check("dbl_then_good_fbe", int'(fb_edges), 1);
        check("dbl_then_good_lock", int'(lock), 1);
        run_period(200, 2, 14, 1'b0);
        run_period(200, 2, 14, 1'b0);
        run_period(200, 1, 14, 1'b0);
        check("two_dbl_lock", int'(lock), 0);

        // Reference disappears while locked.
        repeat (8) run_period(200, 1, 14, 1'b0);
        check("relock2", int'(lock), 1);
        base = lost_pulses;
        gap(450);
        check("to_ref_lost", int'(ref_lost), 1);
        check("to_lock", int'(lock), 0);
        check("to_state", int'(state), 0);
        check("to_pulses", lost_pulses - base, 1);
        check("to_period_hold", int'(ref_period), 200);
        run_period(200, 1, 14, 1'b0);
        check("to_recover_ref_lost", int'(ref_lost), 0);
        check("to_recover_state", int'(state), 1);

        // Feedback edge aligned with the reference edge.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (9) run_period(200, 1, 5, 1'b1);
        check("al_lock", int'(lock), 1);
        check("al_fbe", int'(fb_edges), 1);
        check("al_state", int'(state), 2);

        // Reference edge on exactly the timeout cycle: the edge wins.
        run_period(200, 1, 5, 1'b1);
        gap(200);
        run_period(200, 1, 5, 1'b1);
        check("tie_period", int'(ref_period), 400);
        check("tie_ref_lost", int'(ref_lost), 0);
        check("tie_lock", int'(lock), 1);

        // One-cycle reset while locked.
        base = lost_pulses;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rl_lock", int'(lock), 0);
        check("rl_state", int'(state), 0);
        check("rl_period", int'(ref_period), 0);
        check("rl_fbe", int'(fb_edges), 0);
        check("rl_ref_lost", int'(ref_lost), 0);
        check("rl_lost_lock", int'(lost_lock), 0);
        tick();
        tick();
        check("rl_pulses", lost_pulses - base, 0);

        // Timeout one cycle before the next reference edge.
        repeat (9) run_period(200, 1, 6, 1'b0);
        base = lost_pulses;
        run_period(200, 1, 6, 1'b0);
        gap(201);
        run_period(200, 1, 6, 1'b0);
        check("late_pulses", lost_pulses - base, 1);
        check("late_state", int'(state), 1);
        check("late_ref_lost", int'(ref_lost), 0);

        // Randomized periods, codes, feedback counts and gaps.
        c = 8;
        for (int n = 0; n < 80; n++) begin
            p = 100 + int'($urandom_range(0, 200));
            nfb = 1;
            al = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) nfb = 2 * int'($urandom_range(0, 1));
                else c = (c + 3 + int'($urandom_range(0, 4))) % 16;
            end else begin
                c = c + int'($urandom_range(0, 2)) - 1;
                if (c < 0) c = 0;
                if (c > 15) c = 15;
            end
            if ($urandom_range(0, 24) == 0) gap(int'(T_OUT) - 50 + int'($urandom_range(0, 100)));
            run_period(p, nfb, c, al);
        end
        gap(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
